sm83_prefetch: RTL
==================

Name: sm83_prefetch

Overview:
Instruction-byte prefetch stage for the sm83 core, directly upstream of the test memory's read port.
- Drives the memory read address and captures the combinational read data into a small FIFO of opcode/operand bytes.
- Presents those bytes to the decoder over a valid/ready handshake.
- Handles PC redirects (jumps, interrupts) and snoops memory writes so that self-modifying code never executes stale bytes.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RESET_PC, 16'h0000, fetch address after reset.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- mem_r_addr  output  addr_t(16)  memory read address; combinational, equal to fetch_pc.
- mem_r_data  input  data_t(8)  combinational read data for mem_r_addr.
- redirect_valid  input  1  load a new fetch PC.
- redirect_pc  input  16  new PC.
- snoop_wen  input  1  memory write occurring this cycle.
- snoop_addr  input  16  address of that write.
- out_valid  output  1  head byte available.
- out_data  output  8  head byte.
- out_ready  input  1  decoder accepts the head byte.

Behaviour:
- Reset: sync, active-high, all state cleared at the clk edge where rst=1.
  - count=0, fetch_pc=RESET_PC, out_valid=0, out_data=8'h00, mem_r_addr=RESET_PC.
  - Reset has priority over every other input. Asserting it mid-operation discards all entries.
- Storage: circular FIFO, DEPTH entries. Each entry holds {byte, pc[15:0]}; head/tail pointers are log2(DEPTH) bits and wrap naturally.
- out_valid = (count != 0). out_data = head byte (registered storage, no combinational path from mem_r_data).
- Pop: out_valid && out_ready at the edge.
- Push: when !redirect_valid, no snoop hit on fetch_pc, and (count < DEPTH or pop).
  - Stores {mem_r_data, fetch_pc}.
  - fetch_pc <= fetch_pc + 1, mod 2^16 (16'hFFFF wraps to 16'h0000).
- Simultaneous push and pop: count unchanged. Full with pop: push allowed.
- Latency: one byte per cycle steady state. First out_valid occurs the cycle after the first push.
  - After rst deassert: push in cycle 0, out_valid in cycle 1.
- Redirect (priority over snoop, push and pop):
  - FIFO emptied; fetch_pc <= redirect_pc; no push; any pop that cycle is ignored.
  - Redirect at cycle N: push from redirect_pc at N+1, out_valid at N+2.
- Snoop (when snoop_wen and not redirect):
  - A pop completing this cycle is treated as consuming the pre-write value, so the popped head is never a hit.
  - Hit = the oldest remaining valid entry whose pc == snoop_addr.
  - On a hit: that entry and all younger entries are discarded (tail and count adjusted), fetch_pc <= hit entry's pc, and no push this cycle.
  - No entry hit but snoop_addr == fetch_pc: push suppressed and fetch_pc held, so the byte is refetched after the write lands.
  - Otherwise: no effect.
- The memory write commits at the same edge, so the refetch in the next cycle reads the new data.

Optional Feature:
- Macro: SM83_PREFETCH_PC_TAG_EN.
- Defined: adds output port out_pc [15:0] = pc of the head entry. Reset value RESET_PC; holds its value when out_valid=0.
- Undefined: port absent. Per-entry pc storage is still required for snooping.

Test Plan:
1. Memory 0:3E,1:BE,2:3C, rest FF; out_ready=1 from reset.
   -> out_data 3E,BE,3C,FF,FF on consecutive cycles starting 1 cycle after rst deasserts.
2. out_ready=0 after reset.
   -> count saturates at 4; mem_r_addr holds 16'h0004.
   Then out_ready=1 -> 3E,BE,3C,FF,FF continues with no gap or duplicate.
3. FIFO full at 0..3, redirect_valid with redirect_pc=16'h0100 (mem[0x100]=AA, mem[0x101]=BB).
   -> out_valid=0 the next cycle, then AA, BB; no stale byte appears.
4. FIFO holds pcs 0..3, out_ready=0, snoop write of 16'h0002 with data 77.
   -> entries 2 and 3 dropped, fetch_pc=2; after ready the sequence is 3E,BE,77,FF.
5. Same as scenario 4 but the write is to 16'h0000 while head pc 0 is popped.
   -> 3E delivered, no discard, sequence continues BE,3C.
6. redirect_pc=16'hFFFE, mem[FFFE]=11, mem[FFFF]=22.
   -> out_data 11,22,3E,BE; mem_r_addr wraps to 16'h0000.
   Then assert rst while full -> out_valid=0 next cycle and mem_r_addr=RESET_PC.

Source files
------------

// File: rtl/sm83_prefetch.sv
// sm83 instruction-byte prefetch FIFO with PC redirect and memory-write snooping.
// Optional: define SM83_PREFETCH_PC_TAG_EN to expose the head entry's pc on out_pc.
module sm83_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_r_addr,
  input  logic [7:0]  mem_r_data,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        snoop_wen,
  input  logic [15:0] snoop_addr,
  output logic        out_valid,
  output logic [7:0]  out_data,
`ifdef SM83_PREFETCH_PC_TAG_EN
  output logic [15:0] out_pc,
`endif
  input  logic        out_ready
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    byte_q [DEPTH];
  logic [15:0]   pc_q   [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [15:0]   fetch_pc;

  logic          pop;
  logic          push;
  logic          full;
  logic          hit;
  logic [AW-1:0] hit_off;
  logic [15:0]   hit_pc;
  logic          snoop_block;

  assign mem_r_addr = fetch_pc;
  assign out_valid  = (count != '0);
  assign out_data   = byte_q[head];
  assign full       = (count == CW'(DEPTH));
  assign pop        = out_valid && out_ready;

  // Oldest surviving entry matching the write; a head being popped this cycle already read the old value.
  always_comb begin
    hit     = 1'b0;
    hit_off = '0;
    hit_pc  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!hit && (CW'(i) < count) && !(pop && (i == 0)) &&
          (pc_q[head + AW'(i)] == snoop_addr)) begin
        hit     = 1'b1;
        hit_off = AW'(i);
        hit_pc  = pc_q[head + AW'(i)];
      end
    end
  end

  assign snoop_block = snoop_wen && (hit || (snoop_addr == fetch_pc));
  assign push        = !redirect_valid && !snoop_block && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      fetch_pc <= RESET_PC;
      for (int i = 0; i < int'(DEPTH); i++) begin
        byte_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (redirect_valid) begin
      tail     <= head;
      count    <= '0;
      fetch_pc <= redirect_pc;
    end else if (snoop_wen && hit) begin
      // Drop the hit entry and everything younger; refetch from the hit pc.
      tail     <= head + hit_off;
      count    <= CW'(hit_off) - CW'(pop);
      fetch_pc <= hit_pc;
      if (pop) head <= head + 1'b1;
    end else begin
      if (push) begin
        byte_q[tail] <= mem_r_data;
        pc_q[tail]   <= fetch_pc;
        tail         <= tail + 1'b1;
        fetch_pc     <= fetch_pc + 16'd1;
      end
      if (pop) head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

`ifdef SM83_PREFETCH_PC_TAG_EN
  logic [15:0] last_pc;

  always_ff @(posedge clk) begin
    if (rst)            last_pc <= RESET_PC;
    else if (out_valid) last_pc <= pc_q[head];
  end

  assign out_pc = out_valid ? pc_q[head] : last_pc;
`endif

endmodule
